cam_table: RTL

- Parametrised, fully associative key/data CAM with valid tracking, insert-or-update, invalidate-by-key, flush and round-robin replacement when full.
- Lookup result is registered (1-cycle latency). When an insert displaces a valid entry, the evicted key/data is reported so the owning structure can write it back.
- Used as a generic small associative table (TLB-style or tag store) inside the processor memory subsystem.

---
 rtl/cam_table.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cam_table.sv
// Fully associative key/data CAM: insert-or-update, invalidate-by-key, flush,
// round-robin replacement with evicted-entry reporting, registered lookup.
module cam_table #(
   parameter int KEY_WIDTH  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_ENTRY  = 8,
   localparam int IDX_W     = $clog2(NUM_ENTRY),
   localparam int CNT_W     = $clog2(NUM_ENTRY + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lookup_en,
   input  logic [KEY_WIDTH-1:0]  lookup_key,
   output logic                  lookup_hit,
   output logic [IDX_W-1:0]      lookup_index,
   output logic [DATA_WIDTH-1:0] lookup_data,
   input  logic                  write_en,
   input  logic [KEY_WIDTH-1:0]  write_key,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  inval_en,
   input  logic [KEY_WIDTH-1:0]  inval_key,
   input  logic                  flush,
   output logic                  evict_valid,
   output logic [KEY_WIDTH-1:0]  evict_key,
   output logic [DATA_WIDTH-1:0] evict_data,
   output logic                  full,
   output logic [CNT_W-1:0]      count
);

   logic [KEY_WIDTH-1:0]  key_mem  [NUM_ENTRY];
   logic [DATA_WIDTH-1:0] data_mem [NUM_ENTRY];
   logic [NUM_ENTRY-1:0]  valid;
   logic [NUM_ENTRY-1:0]  valid_nxt;
   logic [IDX_W-1:0]      victim;

   logic [NUM_ENTRY-1:0]  lk_match, wr_match, iv_match;
   logic [IDX_W-1:0]      lk_idx, wr_idx, free_idx, wr_target;
   logic                  lk_hit, wr_hit, wr_go, alloc, repl, is_full;
   logic [CNT_W-1:0]      cnt;

   always_comb begin
      for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
         lk_match[i] = valid[i] && (key_mem[i] == lookup_key);
         wr_match[i] = valid[i] && (key_mem[i] == write_key);
         iv_match[i] = valid[i] && (key_mem[i] == inval_key);
      end
   end

   // Descending scan so the lowest matching/free index wins.
   always_comb begin
      lk_idx   = '0;
      wr_idx   = '0;
      free_idx = '0;
      for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
         if (lk_match[i]) lk_idx   = IDX_W'(i);
         if (wr_match[i]) wr_idx   = IDX_W'(i);
         if (!valid[i])   free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      lk_hit  = |lk_match;
      wr_hit  = |wr_match;
      is_full = &valid;
      wr_go   = write_en && !(inval_en && (inval_key == write_key));
      alloc   = wr_go && !wr_hit && !is_full;
      repl    = wr_go && !wr_hit && is_full;
      if (wr_hit)
         wr_target = wr_idx;
      else if (is_full)
         wr_target = victim;
      else
         wr_target = free_idx;
   end

   // Invalidate first, then the insert may set its target; both use pre-update matches.
   always_comb begin
      valid_nxt = valid;
      if (inval_en)
         valid_nxt = valid_nxt & ~iv_match;
      if (alloc || repl)
         valid_nxt[wr_target] = 1'b1;
   end

   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < NUM_ENTRY; i++)
         cnt = cnt + CNT_W'(valid[i]);
   end

   assign count = cnt;
   assign full  = is_full;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid        <= '0;
         victim       <= '0;
         lookup_hit   <= 1'b0;
         lookup_index <= '0;
         lookup_data  <= '0;
         evict_valid  <= 1'b0;
         evict_key    <= '0;
         evict_data   <= '0;
      end else begin
         if (lookup_en) begin
            lookup_hit   <= lk_hit;
            lookup_index <= lk_hit ? lk_idx : '0;
            lookup_data  <= lk_hit ? data_mem[lk_idx] : '0;
         end else begin
            lookup_hit <= 1'b0;
         end

         if (flush) begin
            valid       <= '0;
            victim      <= '0;
            evict_valid <= 1'b0;
         end else begin
            valid       <= valid_nxt;
            evict_valid <= repl;
            if (repl) begin
               evict_key  <= key_mem[victim];
               evict_data <= data_mem[victim];
               victim     <= (victim == IDX_W'(NUM_ENTRY - 1)) ? '0 : victim + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !flush && wr_go) begin
         key_mem[wr_target]  <= write_key;
         data_mem[wr_target] <= write_data;
      end
   end

endmodule
